hoplite_node_interface: RTL and testbench

HOPLITE_NODE_INTERFACE -- requirements
Module: hoplite_node_interface

---
 rtl/hoplite_node_interface.sv | 187 ++++++++++++++++++
 tb/tb_hoplite_node_interface.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hoplite_node_interface.sv
// Hoplite NoC node interface: field-register TX packet assembly and an RX FIFO read as header/element words.
// Optional drop counter enabled by defining HOPLITE_NI_DROP_COUNT_EN.
module hoplite_node_interface #(
    parameter int COORD_BITS           = 1,
    parameter int MULTICAST_GROUP_BITS = 1,
    parameter int MATRIX_TYPE_BITS     = 1,
    parameter int MATRIX_COORD_BITS    = 8,
    parameter int MATRIX_ELEMENT_BITS  = 32,
    parameter int FIFO_DEPTH           = 4,
    localparam int PACKET_BITS = 2*COORD_BITS + MULTICAST_GROUP_BITS + 2 + MATRIX_TYPE_BITS
                                 + 2*MATRIX_COORD_BITS + MATRIX_ELEMENT_BITS
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [COORD_BITS-1:0]           x_coord_out,
    input  logic                            x_coord_out_valid,
    input  logic [COORD_BITS-1:0]           y_coord_out,
    input  logic                            y_coord_out_valid,
    input  logic [MULTICAST_GROUP_BITS-1:0] multicast_group_out,
    input  logic                            multicast_group_out_valid,
    input  logic                            done_flag_out,
    input  logic                            done_flag_out_valid,
    input  logic                            result_flag_out,
    input  logic                            result_flag_out_valid,
    input  logic [MATRIX_TYPE_BITS-1:0]     matrix_type_out,
    input  logic                            matrix_type_out_valid,
    input  logic [MATRIX_COORD_BITS-1:0]    matrix_x_coord_out,
    input  logic                            matrix_x_coord_out_valid,
    input  logic [MATRIX_COORD_BITS-1:0]    matrix_y_coord_out,
    input  logic                            matrix_y_coord_out_valid,
    input  logic [MATRIX_ELEMENT_BITS-1:0]  matrix_element_out,
    input  logic                            matrix_element_out_valid,
    input  logic                            packet_complete_out,
    output logic                            message_out_ready,
    output logic [31:0]                     message_in,
    output logic                            message_in_valid,
    output logic                            message_in_available,
    input  logic                            message_in_read,
    output logic [PACKET_BITS-1:0]          packet_out,
    output logic                            packet_out_valid,
    input  logic                            packet_out_ready,
    input  logic [PACKET_BITS-1:0]          packet_in,
    input  logic                            packet_in_valid,
    output logic [15:0]                     drop_count
);

    localparam int MY_LSB = MATRIX_ELEMENT_BITS;
    localparam int MX_LSB = MY_LSB + MATRIX_COORD_BITS;
    localparam int TY_LSB = MX_LSB + MATRIX_COORD_BITS;
    localparam int RS_LSB = TY_LSB + MATRIX_TYPE_BITS;
    localparam int DN_LSB = RS_LSB + 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic {HEADER, ELEMENT} rd_state_e;

    logic [COORD_BITS-1:0]           x_q, y_q;
    logic [MULTICAST_GROUP_BITS-1:0] mg_q;
    logic                            done_q, result_q;
    logic [MATRIX_TYPE_BITS-1:0]     type_q;
    logic [MATRIX_COORD_BITS-1:0]    mx_q, my_q;
    logic [MATRIX_ELEMENT_BITS-1:0]  el_q;
    logic [PACKET_BITS-1:0]          pkt_q;
    logic                            pkt_vld_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q       <= '0;
            y_q       <= '0;
            mg_q      <= '0;
            done_q    <= 1'b0;
            result_q  <= 1'b0;
            type_q    <= '0;
            mx_q      <= '0;
            my_q      <= '0;
            el_q      <= '0;
            pkt_q     <= '0;
            pkt_vld_q <= 1'b0;
        end else begin
            if (x_coord_out_valid)         x_q      <= x_coord_out;
            if (y_coord_out_valid)         y_q      <= y_coord_out;
            if (multicast_group_out_valid) mg_q     <= multicast_group_out;
            if (done_flag_out_valid)       done_q   <= done_flag_out;
            if (result_flag_out_valid)     result_q <= result_flag_out;
            if (matrix_type_out_valid)     type_q   <= matrix_type_out;
            if (matrix_x_coord_out_valid)  mx_q     <= matrix_x_coord_out;
            if (matrix_y_coord_out_valid)  my_q     <= matrix_y_coord_out;
            if (matrix_element_out_valid)  el_q     <= matrix_element_out;
            // A send request is only honoured when the slot was already empty before this edge.
            if (pkt_vld_q && packet_out_ready) begin
                pkt_vld_q <= 1'b0;
            end else if (!pkt_vld_q && packet_complete_out) begin
                pkt_q     <= {x_q, y_q, mg_q, done_q, result_q, type_q, mx_q, my_q, el_q};
                pkt_vld_q <= 1'b1;
            end
        end
    end

    assign packet_out        = pkt_q;
    assign packet_out_valid  = pkt_vld_q;
    assign message_out_ready = !pkt_vld_q;

    logic [PACKET_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]       count_q;
    rd_state_e              state_q, state_d;
    logic                   empty, full, push, pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign push  = packet_in_valid && !full;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= packet_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= HEADER;
        end else begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(push);
            rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
            count_q  <= count_q + CNT_W'(push) - CNT_W'(pop);
            state_q  <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            HEADER:  if (message_in_read && !empty) state_d = ELEMENT;
            ELEMENT: if (message_in_read && !empty) begin
                state_d = HEADER;
                pop     = 1'b1;
            end
            default: state_d = HEADER;
        endcase
    end

    logic [PACKET_BITS-1:0] head;
    logic [7:0]             mx_w, my_w, type_w;
    logic [31:0]            el_w;
    logic                   unused_head;

    assign head        = mem_q[rd_ptr_q];
    assign unused_head = ^head[PACKET_BITS-1:DN_LSB+1];

    always_comb begin
        mx_w   = '0;
        my_w   = '0;
        type_w = '0;
        el_w   = '0;
        mx_w[MATRIX_COORD_BITS-1:0]   = head[MX_LSB +: MATRIX_COORD_BITS];
        my_w[MATRIX_COORD_BITS-1:0]   = head[MY_LSB +: MATRIX_COORD_BITS];
        type_w[MATRIX_TYPE_BITS-1:0]  = head[TY_LSB +: MATRIX_TYPE_BITS];
        el_w[MATRIX_ELEMENT_BITS-1:0] = head[MATRIX_ELEMENT_BITS-1:0];
        message_in = '0;
        if (!empty) begin
            if (state_q == HEADER) message_in = {6'b0, head[DN_LSB], head[RS_LSB], type_w, my_w, mx_w};
            else                   message_in = el_w;
        end
    end

    assign message_in_valid     = !empty;
    assign message_in_available = !empty && (state_q == HEADER);

`ifdef HOPLITE_NI_DROP_COUNT_EN
    logic [15:0] drop_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q <= '0;
        end else if (packet_in_valid && full && drop_q != 16'hFFFF) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign drop_count = drop_q;
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_hoplite_node_interface.sv
// Directed self-checking bench for hoplite_node_interface at default parameters.
`timescale 1ns/1ps
module tb_hoplite_node_interface;

    logic        clk = 1'b0;
    logic        reset;
    logic        x_coord_out, x_coord_out_valid, y_coord_out, y_coord_out_valid;
    logic        multicast_group_out, multicast_group_out_valid;
    logic        done_flag_out, done_flag_out_valid, result_flag_out, result_flag_out_valid;
    logic        matrix_type_out, matrix_type_out_valid;
    logic [7:0]  matrix_x_coord_out, matrix_y_coord_out;
    logic        matrix_x_coord_out_valid, matrix_y_coord_out_valid;
    logic [31:0] matrix_element_out;
    logic        matrix_element_out_valid, packet_complete_out;
    logic        message_out_ready;
    logic [31:0] message_in;
    logic        message_in_valid, message_in_available, message_in_read;
    logic [53:0] packet_out, packet_in;
    logic        packet_out_valid, packet_out_ready, packet_in_valid;
    logic [15:0] drop_count;

    int compared = 0;
    int mismatched = 0;
    int tx_count = 0;
    int exp_drop = 0;
    int drop_inc;

    hoplite_node_interface dut (
        .clk(clk), .reset(reset),
        .x_coord_out(x_coord_out), .x_coord_out_valid(x_coord_out_valid),
        .y_coord_out(y_coord_out), .y_coord_out_valid(y_coord_out_valid),
        .multicast_group_out(multicast_group_out), .multicast_group_out_valid(multicast_group_out_valid),
        .done_flag_out(done_flag_out), .done_flag_out_valid(done_flag_out_valid),
        .result_flag_out(result_flag_out), .result_flag_out_valid(result_flag_out_valid),
        .matrix_type_out(matrix_type_out), .matrix_type_out_valid(matrix_type_out_valid),
        .matrix_x_coord_out(matrix_x_coord_out), .matrix_x_coord_out_valid(matrix_x_coord_out_valid),
        .matrix_y_coord_out(matrix_y_coord_out), .matrix_y_coord_out_valid(matrix_y_coord_out_valid),
        .matrix_element_out(matrix_element_out), .matrix_element_out_valid(matrix_element_out_valid),
        .packet_complete_out(packet_complete_out),
        .message_out_ready(message_out_ready), .message_in(message_in),
        .message_in_valid(message_in_valid), .message_in_available(message_in_available),
        .message_in_read(message_in_read),
        .packet_out(packet_out), .packet_out_valid(packet_out_valid), .packet_out_ready(packet_out_ready),
        .packet_in(packet_in), .packet_in_valid(packet_in_valid),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (packet_out_valid && packet_out_ready) tx_count++;

    function automatic logic [53:0] pk(input logic x, input logic y, input logic mg, input logic dn,
                                       input logic rs, input logic ty, input logic [7:0] mx,
                                       input logic [7:0] my, input logic [31:0] el);
        return {x, y, mg, dn, rs, ty, mx, my, el};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        x_coord_out = 0; x_coord_out_valid = 0; y_coord_out = 0; y_coord_out_valid = 0;
        multicast_group_out = 0; multicast_group_out_valid = 0;
        done_flag_out = 0; done_flag_out_valid = 0; result_flag_out = 0; result_flag_out_valid = 0;
        matrix_type_out = 0; matrix_type_out_valid = 0;
        matrix_x_coord_out = 0; matrix_x_coord_out_valid = 0;
        matrix_y_coord_out = 0; matrix_y_coord_out_valid = 0;
        matrix_element_out = 0; matrix_element_out_valid = 0;
        packet_complete_out = 0; message_in_read = 0; packet_out_ready = 0;
        packet_in = '0; packet_in_valid = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1; tick(); tick(); reset = 0;
        compared++; if (message_out_ready !== 1'b1) begin mismatched++; $display("FAIL rst_ready: got %b want 1", message_out_ready); end
        compared++; if (packet_out_valid !== 1'b0) begin mismatched++; $display("FAIL rst_pvalid: got %b want 0", packet_out_valid); end
        compared++; if (packet_out !== 54'd0) begin mismatched++; $display("FAIL rst_packet: got %h want 0", packet_out); end
        compared++; if (message_in_valid !== 1'b0) begin mismatched++; $display("FAIL rst_mvalid: got %b want 0", message_in_valid); end
        compared++; if (message_in_available !== 1'b0) begin mismatched++; $display("FAIL rst_avail: got %b want 0", message_in_available); end
        compared++; if (drop_count !== 16'd0) begin mismatched++; $display("FAIL rst_drop: got %0d want 0", drop_count); end
    endtask

    task automatic test_basic_send();
        logic [53:0] exp;
        int base;
        exp = pk(1, 0, 0, 0, 0, 0, 8'd3, 8'd0, 32'hDEADBEEF);
        x_coord_out = 1; x_coord_out_valid = 1; y_coord_out = 0; y_coord_out_valid = 1;
        matrix_element_out = 32'hDEADBEEF; matrix_element_out_valid = 1;
        matrix_x_coord_out = 8'd3; matrix_x_coord_out_valid = 1;
        tick();
        clear_inputs(); packet_complete_out = 1;
        base = tx_count;
        tick();
        packet_complete_out = 0;
        compared++; if (packet_out_valid !== 1'b1) begin mismatched++; $display("FAIL send_valid: got %b want 1", packet_out_valid); end
        compared++; if (packet_out !== exp) begin mismatched++; $display("FAIL send_packet: got %h want %h", packet_out, exp); end
        compared++; if (message_out_ready !== 1'b0) begin mismatched++; $display("FAIL send_ready: got %b want 0", message_out_ready); end
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                packet_complete_out = 1; matrix_y_coord_out = 8'd9; matrix_y_coord_out_valid = 1;
            end
            tick();
            packet_complete_out = 0; matrix_y_coord_out_valid = 0;
            compared++; if (packet_out_valid !== 1'b1) begin mismatched++; $display("FAIL hold_valid[%0d]: got %b want 1", i, packet_out_valid); end
            compared++; if (packet_out !== exp) begin mismatched++; $display("FAIL hold_packet[%0d]: got %h want %h", i, packet_out, exp); end
            compared++; if (message_out_ready !== 1'b0) begin mismatched++; $display("FAIL hold_ready[%0d]: got %b want 0", i, message_out_ready); end
        end
        packet_out_ready = 1; packet_complete_out = 1;
        tick();
        packet_out_ready = 0; packet_complete_out = 0;
        compared++; if (packet_out_valid !== 1'b0) begin mismatched++; $display("FAIL xfer_valid: got %b want 0", packet_out_valid); end
        compared++; if (message_out_ready !== 1'b1) begin mismatched++; $display("FAIL xfer_ready: got %b want 1", message_out_ready); end
        tick(); tick();
        compared++; if (tx_count - base !== 1) begin mismatched++; $display("FAIL one_injected: got %0d want 1", tx_count - base); end
        compared++; if (packet_out_valid !== 1'b0) begin mismatched++; $display("FAIL idle_valid: got %b want 0", packet_out_valid); end
    endtask

    task automatic test_field_persist();
        logic [53:0] exp;
        exp = pk(1, 0, 0, 0, 0, 0, 8'd3, 8'd9, 32'hDEADBEEF);
        packet_complete_out = 1; matrix_element_out = 32'h11; matrix_element_out_valid = 1;
        tick();
        packet_complete_out = 0; matrix_element_out_valid = 0;
        compared++; if (packet_out !== exp) begin mismatched++; $display("FAIL persist_packet: got %h want %h", packet_out, exp); end
        packet_out_ready = 1; tick(); packet_out_ready = 0;
        packet_complete_out = 1; tick(); packet_complete_out = 0;
        exp = pk(1, 0, 0, 0, 0, 0, 8'd3, 8'd9, 32'h11);
        compared++; if (packet_out !== exp) begin mismatched++; $display("FAIL next_packet: got %h want %h", packet_out, exp); end
        packet_out_ready = 1; tick(); packet_out_ready = 0;
        compared++; if (packet_out_valid !== 1'b0) begin mismatched++; $display("FAIL next_drain: got %b want 0", packet_out_valid); end
    endtask

    task automatic test_basic_receive();
        packet_in = pk(0, 0, 0, 1, 0, 1, 8'd5, 8'd2, 32'd7); packet_in_valid = 1;
        tick();
        packet_in_valid = 0;
        compared++; if (message_in_valid !== 1'b1) begin mismatched++; $display("FAIL rx_valid: got %b want 1", message_in_valid); end
        compared++; if (message_in_available !== 1'b1) begin mismatched++; $display("FAIL rx_avail: got %b want 1", message_in_available); end
        compared++; if (message_in !== 32'h0201_0205) begin mismatched++; $display("FAIL rx_header: got %h want 02010205", message_in); end
        message_in_read = 1; tick(); message_in_read = 0;
        compared++; if (message_in !== 32'd7) begin mismatched++; $display("FAIL rx_element: got %h want 7", message_in); end
        compared++; if (message_in_available !== 1'b0) begin mismatched++; $display("FAIL rx_avail_elem: got %b want 0", message_in_available); end
        message_in_read = 1; tick(); message_in_read = 0;
        compared++; if (message_in_valid !== 1'b0) begin mismatched++; $display("FAIL rx_empty: got %b want 0", message_in_valid); end
        message_in_read = 1; tick(); message_in_read = 0;
        compared++; if (message_in_valid !== 1'b0) begin mismatched++; $display("FAIL rx_empty_read: got %b want 0", message_in_valid); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 6; i++) begin
            packet_in = pk(0, 0, 0, 0, 1, 0, 8'(i), 8'd0, 32'(100 + i)); packet_in_valid = 1;
            tick();
        end
        packet_in_valid = 0;
        exp_drop += 2 * drop_inc;
        compared++; if (drop_count !== 16'(exp_drop)) begin mismatched++; $display("FAIL ovf_drop: got %0d want %0d", drop_count, exp_drop); end
        for (int i = 0; i < 4; i++) begin
            compared++; if (message_in !== (32'h0100_0000 | 32'(i))) begin mismatched++; $display("FAIL ovf_header[%0d]: got %h want %h", i, message_in, 32'h0100_0000 | 32'(i)); end
            message_in_read = 1; tick();
            compared++; if (message_in !== 32'(100 + i)) begin mismatched++; $display("FAIL ovf_element[%0d]: got %0d want %0d", i, message_in, 100 + i); end
            tick(); message_in_read = 0;
        end
        compared++; if (message_in_valid !== 1'b0) begin mismatched++; $display("FAIL ovf_empty: got %b want 0", message_in_valid); end
    endtask

    task automatic test_full_pop();
        logic [31:0] exp_el [3];
        logic [7:0]  exp_mx [3];
        exp_el = '{32'd202, 32'd203, 32'd300};
        exp_mx = '{8'd2, 8'd3, 8'd7};
        for (int i = 0; i < 4; i++) begin
            packet_in = pk(0, 0, 0, 0, 0, 0, 8'(i), 8'd0, 32'(200 + i)); packet_in_valid = 1;
            tick();
        end
        packet_in_valid = 0;
        message_in_read = 1; tick();
        packet_in = pk(0, 0, 0, 0, 0, 0, 8'd9, 8'd0, 32'd999); packet_in_valid = 1;
        tick();
        message_in_read = 0; packet_in_valid = 0;
        exp_drop += drop_inc;
        compared++; if (drop_count !== 16'(exp_drop)) begin mismatched++; $display("FAIL fullpop_drop: got %0d want %0d", drop_count, exp_drop); end
        compared++; if (message_in !== 32'd1) begin mismatched++; $display("FAIL fullpop_head: got %h want 1", message_in); end
        message_in_read = 1; tick();
        compared++; if (message_in !== 32'd201) begin mismatched++; $display("FAIL fullpop_elem: got %0d want 201", message_in); end
        packet_in = pk(0, 0, 0, 0, 0, 0, 8'd7, 8'd0, 32'd300); packet_in_valid = 1;
        tick();
        message_in_read = 0; packet_in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            compared++; if (message_in !== 32'(exp_mx[i])) begin mismatched++; $display("FAIL occ_header[%0d]: got %h want %h", i, message_in, exp_mx[i]); end
            message_in_read = 1; tick();
            compared++; if (message_in !== exp_el[i]) begin mismatched++; $display("FAIL occ_element[%0d]: got %0d want %0d", i, message_in, exp_el[i]); end
            tick(); message_in_read = 0;
        end
        compared++; if (message_in_valid !== 1'b0) begin mismatched++; $display("FAIL occ_empty: got %b want 0", message_in_valid); end
    endtask

    task automatic test_reset_mid();
        x_coord_out = 1; x_coord_out_valid = 1; matrix_element_out = 32'h55; matrix_element_out_valid = 1;
        tick();
        clear_inputs(); packet_complete_out = 1; tick(); packet_complete_out = 0;
        for (int i = 0; i < 2; i++) begin
            packet_in = pk(0, 0, 0, 1, 1, 1, 8'(i), 8'd1, 32'd42); packet_in_valid = 1;
            tick();
        end
        packet_in_valid = 0;
        compared++; if (packet_out_valid !== 1'b1 || message_in_valid !== 1'b1) begin mismatched++; $display("FAIL pre_reset: got %b/%b want 1/1", packet_out_valid, message_in_valid); end
        reset = 1; packet_complete_out = 1; packet_in_valid = 1; message_in_read = 1; packet_out_ready = 1;
        tick();
        reset = 0; clear_inputs();
        exp_drop = 0;
        compared++; if (packet_out_valid !== 1'b0) begin mismatched++; $display("FAIL mid_pvalid: got %b want 0", packet_out_valid); end
        compared++; if (packet_out !== 54'd0) begin mismatched++; $display("FAIL mid_packet: got %h want 0", packet_out); end
        compared++; if (message_out_ready !== 1'b1) begin mismatched++; $display("FAIL mid_ready: got %b want 1", message_out_ready); end
        compared++; if (message_in_valid !== 1'b0 || message_in_available !== 1'b0) begin mismatched++; $display("FAIL mid_rx: got %b/%b want 0/0", message_in_valid, message_in_available); end
        compared++; if (message_in !== 32'd0) begin mismatched++; $display("FAIL mid_msg: got %h want 0", message_in); end
        compared++; if (drop_count !== 16'd0) begin mismatched++; $display("FAIL mid_drop: got %0d want 0", drop_count); end
        packet_complete_out = 1; tick(); packet_complete_out = 0;
        compared++; if (packet_out_valid !== 1'b1 || packet_out !== 54'd0) begin mismatched++; $display("FAIL cleared_fields: got %b/%h want 1/0", packet_out_valid, packet_out); end
        packet_out_ready = 1; tick(); packet_out_ready = 0;
        packet_in = pk(0, 0, 0, 0, 1, 1, 8'h12, 8'h34, 32'hCAFE); packet_in_valid = 1;
        tick();
        packet_in_valid = 0;
        compared++; if (message_in !== 32'h0101_3412) begin mismatched++; $display("FAIL post_header: got %h want 01013412", message_in); end
        message_in_read = 1; tick(); message_in_read = 0;
        compared++; if (message_in !== 32'hCAFE) begin mismatched++; $display("FAIL post_element: got %h want cafe", message_in); end
        message_in_read = 1; tick(); message_in_read = 0;
        compared++; if (message_in_valid !== 1'b0) begin mismatched++; $display("FAIL post_empty: got %b want 0", message_in_valid); end
    endtask

    initial begin
`ifdef HOPLITE_NI_DROP_COUNT_EN
        drop_inc = 1;
`else
        drop_inc = 0;
`endif
        reset = 1;
        clear_inputs();
        test_reset();
        test_basic_send();
        test_field_persist();
        test_basic_receive();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
